// File: rtl/accelbrot_com_mult_feeder_if.sv
// Operand-load and word-stream bundle of the multiplier feeder.
// slave = the feeder itself, master = the host/consumer side.
interface accelbrot_com_mult_feeder_if #(
    parameter int NWORDS = 8,
    parameter int WWIDTH = 34
);
    localparam int HWIDTH = WWIDTH / 2;
    localparam int AW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int PW     = (NWORDS > 1) ? $clog2(2 * NWORDS) : 1;

    logic              wr_en;
    logic              wr_sel;
    logic [AW-1:0]     wr_addr;
    logic [WWIDTH-1:0] wr_data;
    logic              go;
    logic              busy;
    logic              done;
    logic [WWIDTH-1:0] a;
    logic [HWIDTH-1:0] b;
    logic              ab_start;
    logic              ab_valid;
    logic              ab_last;
    logic [PW-1:0]     pass_idx;

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, go,
        output busy, done, a, b, ab_start, ab_valid, ab_last, pass_idx
    );

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, go,
        input  busy, done, a, b, ab_start, ab_valid, ab_last, pass_idx
    );
endinterface

// File: rtl/accelbrot_com_mult_feeder.sv
// Word-serial operand sequencer: streams A LSW-first once per half-word of B,
// each pass followed by a zero flush word, for the half-word x multi-word multiplier.
module accelbrot_com_mult_feeder #(
    parameter int NWORDS = 8,
    parameter int WWIDTH = 34
) (
    input  logic                       clk,
    input  logic                       rstn,
    accelbrot_com_mult_feeder_if.slave bus
);
    localparam int HWIDTH = WWIDTH / 2;
    localparam int AW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int PW     = (NWORDS > 1) ? $clog2(2 * NWORDS) : 1;
    localparam int CW     = $clog2(NWORDS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_WORD = CW'(NWORDS);
    localparam logic [PW-1:0] LAST_PASS = PW'(2 * NWORDS - 1);

    logic [WWIDTH-1:0] mem_a_q [NWORDS];
    logic [WWIDTH-1:0] mem_a_d [NWORDS];
    logic [WWIDTH-1:0] mem_b_q [NWORDS];
    logic [WWIDTH-1:0] mem_b_d [NWORDS];

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic [PW-1:0]     pass_cnt_q, pass_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WWIDTH-1:0] a_q, a_d;
    logic [HWIDTH-1:0] b_q, b_d;
    logic              ab_start_q, ab_start_d;
    logic              ab_valid_q, ab_valid_d;
    logic              ab_last_q, ab_last_d;
    logic [PW-1:0]     pass_idx_q, pass_idx_d;

    logic              wr_ok_s;
    logic              load_s;
    logic [CW-1:0]     nxt_word_s;
    logic [PW-1:0]     nxt_pass_s;
    logic [AW-1:0]     rd_word_s;
    logic [AW-1:0]     rd_pass_s;
    logic [WWIDTH-1:0] b_word_s;

    // Operand register files; a go in the same cycle takes priority over a write.
    always_comb begin
        mem_a_d = mem_a_q;
        mem_b_d = mem_b_q;
        wr_ok_s = (state_q == ST_IDLE) && bus.wr_en && !bus.go;
        if (wr_ok_s && bus.wr_sel) begin
            mem_b_d[bus.wr_addr] = bus.wr_data;
        end else if (wr_ok_s) begin
            mem_a_d[bus.wr_addr] = bus.wr_data;
        end else begin
            mem_a_d = mem_a_q;
        end
    end

    // Sequencer: picks the next (word, pass) position and the state transition.
    always_comb begin
        state_d    = state_q;
        load_s     = 1'b0;
        nxt_word_s = {CW{1'b0}};
        nxt_pass_s = {PW{1'b0}};
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.go) begin
                    state_d = ST_RUN;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if ((word_cnt_q == LAST_WORD) && (pass_cnt_q == LAST_PASS)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (word_cnt_q == LAST_WORD) begin
                    load_s     = 1'b1;
                    nxt_pass_s = pass_cnt_q + PW'(1);
                end else begin
                    load_s     = 1'b1;
                    nxt_word_s = word_cnt_q + CW'(1);
                    nxt_pass_s = pass_cnt_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output word for the next position; the flush slot index aliases a real word but is masked.
    always_comb begin
        rd_word_s  = AW'(nxt_word_s);
        rd_pass_s  = AW'(nxt_pass_s >> 1);
        b_word_s   = mem_b_q[rd_pass_s];
        word_cnt_d = word_cnt_q;
        pass_cnt_d = pass_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        pass_idx_d = pass_idx_q;
        busy_d     = 1'b0;
        ab_valid_d = 1'b0;
        ab_start_d = 1'b0;
        ab_last_d  = 1'b0;
        if (load_s) begin
            word_cnt_d = nxt_word_s;
            pass_cnt_d = nxt_pass_s;
            busy_d     = 1'b1;
            ab_valid_d = 1'b1;
            ab_start_d = (nxt_word_s == {CW{1'b0}});
            ab_last_d  = (nxt_word_s == LAST_WORD);
            a_d        = (nxt_word_s == LAST_WORD) ? {WWIDTH{1'b0}} : mem_a_q[rd_word_s];
            b_d        = nxt_pass_s[0] ? b_word_s[WWIDTH-1:HWIDTH] : b_word_s[HWIDTH-1:0];
            pass_idx_d = nxt_pass_s;
        end else begin
            busy_d     = 1'b0;
        end
    end

    // Operand storage survives reset so a restart reuses the loaded operands.
    always_ff @(posedge clk) begin
        mem_a_q <= mem_a_d;
        mem_b_q <= mem_b_d;
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= {CW{1'b0}};
            pass_cnt_q <= {PW{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            a_q        <= {WWIDTH{1'b0}};
            b_q        <= {HWIDTH{1'b0}};
            ab_start_q <= 1'b0;
            ab_valid_q <= 1'b0;
            ab_last_q  <= 1'b0;
            pass_idx_q <= {PW{1'b0}};
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ab_start_q <= ab_start_d;
            ab_valid_q <= ab_valid_d;
            ab_last_q  <= ab_last_d;
            pass_idx_q <= pass_idx_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.ab_start = ab_start_q;
    assign bus.ab_valid = ab_valid_q;
    assign bus.ab_last  = ab_last_q;
    assign bus.pass_idx = pass_idx_q;
endmodule

// File: tb/tb_accelbrot_com_mult_feeder.sv
// Self-checking bench for accelbrot_com_mult_feeder: table of scenarios, each run
// compared cycle by cycle against a pass/word reference model of the stream.
module tb_accelbrot_com_mult_feeder;
    localparam int NW  = 8;
    localparam int WW  = 34;
    localparam int NP  = 2 * NW;
    localparam int TOT = NP * (NW + 1);

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        valid;
        logic        start;
        logic        last;
        logic [3:0]  pidx;
        logic [16:0] b;
        logic [33:0] a;
    } out_t;

    typedef struct {
        int          a_mode;
        int          b_mode;
        logic [33:0] b0;
        int          dist_at;
        logic        wr_go;
        int          rst_at;
        logic [16:0] exp_b0;
        logic [16:0] exp_b1;
        int          exp_valid;
        int          exp_start;
        int          exp_done;
    } vec_t;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_errors;
    logic [33:0] ref_a [NW];
    logic [33:0] ref_b [NW];
    vec_t vecs [7];

    accelbrot_com_mult_feeder_if #(.NWORDS(NW), .WWIDTH(WW)) bus ();

    accelbrot_com_mult_feeder #(.NWORDS(NW), .WWIDTH(WW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t o;
        o.busy  = bus.busy;
        o.done  = bus.done;
        o.valid = bus.ab_valid;
        o.start = bus.ab_start;
        o.last  = bus.ab_last;
        o.pidx  = bus.pass_idx;
        o.b     = bus.b;
        o.a     = bus.a;
        return o;
    endfunction

    function automatic logic [16:0] b_of(int p);
        logic [33:0] w;
        w = ref_b[p / 2];
        return (p % 2 == 1) ? w[33:17] : w[16:0];
    endfunction

    // Expected outputs c cycles after the go edge.
    function automatic out_t expect_at(int c);
        out_t o;
        int p, k;
        o = '0;
        if (c >= 1 && c <= TOT) begin
            p       = (c - 1) / (NW + 1);
            k       = (c - 1) % (NW + 1);
            o.busy  = 1'b1;
            o.valid = 1'b1;
            o.start = (k == 0);
            o.last  = (k == NW);
            o.pidx  = 4'(p);
            o.b     = b_of(p);
            o.a     = (k < NW) ? ref_a[k] : 34'h0;
        end else begin
            o.done  = (c == TOT + 1);
            o.pidx  = 4'(NP - 1);
            o.b     = b_of(NP - 1);
            o.a     = 34'h0;
        end
        return o;
    endfunction

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic wr(input logic sel, input int idx, input logic [33:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = 3'(idx);
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
        if (sel) ref_b[idx] = d;
        else     ref_a[idx] = d;
    endtask

    task automatic run_seq(input int vi, input vec_t v,
                           output logic [16:0] b_p0, output logic [16:0] b_p1,
                           output int nvalid, output int nstart, output int done_at);
        out_t got, want;
        nvalid  = 0;
        nstart  = 0;
        done_at = -1;
        b_p0    = 17'h0;
        b_p1    = 17'h0;
        @(negedge clk);
        bus.go = 1'b1;
        if (v.wr_go) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 1'b0;
            bus.wr_addr = 3'd0;
            bus.wr_data = ~ref_a[0];
        end
        @(negedge clk);
        bus.go    = 1'b0;
        bus.wr_en = 1'b0;
        for (int c = 1; c <= TOT + 6; c++) begin
            got  = sample();
            want = (v.rst_at > 0 && c > v.rst_at) ? out_t'(0) : expect_at(c);
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL stream v%0d cyc %0d: got %h expected %h", vi, c, got, want);
            end
            if (got.valid) nvalid++;
            if (got.valid && got.start) nstart++;
            if (got.done && done_at < 0) done_at = c;
            if (c == 1) b_p0 = got.b;
            if (c == NW + 2) b_p1 = got.b;
            bus.go    = 1'b0;
            bus.wr_en = 1'b0;
            rstn      = 1'b1;
            if (c == v.dist_at) begin
                bus.go      = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'b0;
                bus.wr_addr = 3'd3;
                bus.wr_data = 34'h3FFFFFFFF;
            end
            if (c == v.rst_at) rstn = 1'b0;
            @(negedge clk);
        end
        bus.go    = 1'b0;
        bus.wr_en = 1'b0;
        rstn      = 1'b1;
    endtask

    initial begin
        logic [16:0] bp0, bp1;
        int nv, ns, dn;
        out_t got;
        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{0, 0, 34'h0, 0, 1'b0, 0, 17'h0, 17'h0, TOT, NP, TOT + 1};
        vecs[1] = '{1, 1, {17'h0ABCD, 17'h01234}, 0, 1'b0, 0, 17'h01234, 17'h0ABCD, TOT, NP, TOT + 1};
        vecs[2] = '{1, 0, 34'h1, 0, 1'b0, 0, 17'h00001, 17'h0, TOT, NP, TOT + 1};
        vecs[3] = '{1, 1, 34'h3FFFFFFFF, 30, 1'b0, 0, 17'h1FFFF, 17'h1FFFF, TOT, NP, TOT + 1};
        vecs[4] = '{2, 2, {17'h01000, 17'h00003}, 0, 1'b1, 0, 17'h00003, 17'h01000, TOT, NP, TOT + 1};
        vecs[5] = '{1, 1, {17'h00055, 17'h000AA}, 0, 1'b0, 5 * (NW + 1) + 5, 17'h000AA, 17'h00055,
                    5 * (NW + 1) + 5, 6, -1};
        vecs[6] = '{2, 2, {17'h00055, 17'h000AA}, 0, 1'b0, 0, 17'h000AA, 17'h00055, TOT, NP, TOT + 1};

        rstn        = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = 3'd0;
        bus.wr_data = 34'h0;
        bus.go      = 1'b0;
        repeat (3) @(negedge clk);
        got = sample();
        n_checks++;
        if (got !== out_t'(0)) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected 0", got);
        end
        rstn = 1'b1;

        for (int vi = 0; vi < 7; vi++) begin
            for (int k = 0; k < NW; k++) begin
                if (vecs[vi].a_mode == 0) wr(1'b0, k, 34'(k + 1));
                else if (vecs[vi].a_mode == 1) wr(1'b0, k, {$urandom_range(3, 0), $urandom()});
            end
            wr(1'b1, 0, vecs[vi].b0);
            for (int k = 1; k < NW; k++) begin
                if (vecs[vi].b_mode == 0) wr(1'b1, k, 34'h0);
                else if (vecs[vi].b_mode == 1) wr(1'b1, k, {$urandom_range(3, 0), $urandom()});
            end
            run_seq(vi, vecs[vi], bp0, bp1, nv, ns, dn);
            check_int($sformatf("v%0d b_pass0", vi), int'(bp0), int'(vecs[vi].exp_b0));
            check_int($sformatf("v%0d b_pass1", vi), int'(bp1), int'(vecs[vi].exp_b1));
            check_int($sformatf("v%0d valid_count", vi), nv, vecs[vi].exp_valid);
            check_int($sformatf("v%0d start_count", vi), ns, vecs[vi].exp_start);
            check_int($sformatf("v%0d done_cycle", vi), dn, vecs[vi].exp_done);
        end

        // go during the DONE cycle must be ignored: nothing starts afterwards.
        @(negedge clk);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        nv = 0;
        for (int c = 1; c <= TOT + 3; c++) begin
            if (bus.ab_valid) nv++;
            if (c == TOT) begin
                @(negedge clk);
                got = sample();
                n_checks++;
                if (!got.done || got.busy) begin
                    n_errors++;
                    $display("FAIL done_then_go: got done=%0b busy=%0b expected done=1 busy=0",
                             got.done, got.busy);
                end
                bus.go = 1'b1;
            end
            @(negedge clk);
            bus.go = 1'b0;
        end
        check_int("valid_after_done_go", nv, TOT);
        got = sample();
        n_checks++;
        if (got.valid || got.busy) begin
            n_errors++;
            $display("FAIL idle_after_done_go: got valid=%0b busy=%0b expected 0 0", got.valid, got.busy);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
